fifo_sync_flags: RTL and testbench

//  Next-generation synchronous single-clock FIFO. Supports any DEPTH >= 2, not only powers of two.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_sync_ram.sv | 28 ++
 rtl/fifo_sync_flags.sv | 129 ++++++++++++
 tb/tb_fifo_sync_flags.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing and pointer helpers for the synchronous flag FIFO.
// Build option: FIFO_FWFT_EN selects first-word-fall-through reads in fifo_sync_flags.
package fifo_pkg;

    // Width of the occupancy counter: must hold 0..depth inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a memory index 0..depth-1.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Advance a pointer, wrapping after the last entry (no extra wrap bit).
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// The read stage (when one is wanted) lives in the FIFO top.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flags.sv
// Synchronous single-clock FIFO for any DEPTH >= 2, with level, almost flags,
// overflow/underflow pulses and rd_valid.
// Build option: FIFO_FWFT_EN -> first-word-fall-through (head shown combinationally,
// rd_en acknowledges it). Undefined -> registered read with one cycle of latency.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          din,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int LW = lvl_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 2) begin : g_chk_depth
        $error("fifo_sync_flags: DEPTH must be at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("fifo_sync_flags: AF_THRESH must be within 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_chk_ae
        $error("fifo_sync_flags: AE_THRESH must be within 0..DEPTH-1");
    end

    logic [LW-1:0]    level_reg, level_next;
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic             overflow_reg, underflow_reg;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rdata;

    // Flags come straight from the registered occupancy.
    assign empty        = (level_reg == '0);
    assign full         = (level_reg == LW'(DEPTH));
    assign almost_full  = (level_reg >= LW'(AF_THRESH));
    assign almost_empty = (level_reg <= LW'(AE_THRESH));
    assign level        = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        level_next = level_reg;
        if (wr_acc && !rd_acc) begin
            level_next = level_reg + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_next = level_reg - LW'(1);
        end
    end

    // Pointers, occupancy and the rejected-request pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= PW'(ptr_inc(int'(wr_ptr_reg), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr_reg <= PW'(ptr_inc(int'(rd_ptr_reg), DEPTH));
            end
            level_reg     <= level_next;
            overflow_reg  <= wr_en && !wr_acc;
            underflow_reg <= rd_en && !rd_acc;
        end
    end

    fifo_sync_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .raddr (rd_ptr_reg),
        .rdata (ram_rdata)
    );

`ifdef FIFO_FWFT_EN
    // Head of the queue is presented as soon as it exists; rd_en only retires it.
    assign dout     = ram_rdata;
    assign rd_valid = !empty;
`else
    logic [WIDTH-1:0] dout_reg;
    logic             rd_valid_reg;

    // Registered read stage: capture the head on an accepted read, otherwise hold dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg     <= '0;
            rd_valid_reg <= 1'b0;
        end else if (rd_acc) begin
            dout_reg     <= ram_rdata;
            rd_valid_reg <= 1'b1;
        end else begin
            rd_valid_reg <= 1'b0;
        end
    end

    assign dout     = dout_reg;
    assign rd_valid = rd_valid_reg;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench: two FIFOs (DEPTH 8 and DEPTH 5) share one stimulus stream and are
// compared every cycle against queue-based models, plus directed literal checks.
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en;
    logic [7:0] din;

    logic [7:0] dout8, dout5;
    logic       rv8, full8, empty8, af8, ae8, ov8, un8;
    logic       rv5, full5, empty5, af5, ae5, ov5, un5;
    logic [3:0] lvl8;
    logic [2:0] lvl5;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_flags #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout8), .rd_valid(rv8), .full(full8), .empty(empty8),
        .almost_full(af8), .almost_empty(ae8), .level(lvl8),
        .overflow(ov8), .underflow(un8)
    );

    fifo_sync_flags #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut5 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout5), .rd_valid(rv5), .full(full5), .empty(empty5),
        .almost_full(af5), .almost_empty(ae5), .level(lvl5),
        .overflow(ov5), .underflow(un5)
    );

    // ---------------- behavioural model ----------------
    typedef logic [7:0] bq_t [$];
    bq_t        q8, q5;
    int         m_depth [2] = '{8, 5};
    int         m_af    [2] = '{6, 4};
    int         m_ae    [2] = '{2, 1};
    logic [7:0] m_dout  [2];
    logic       m_rv    [2];
    logic       m_ov    [2];
    logic       m_un    [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input int k);
        bq_t        q;
        logic       racc, wacc;
        logic [7:0] h;
        if (k == 0) q = q8; else q = q5;
        if (rst) begin
            q.delete();
            m_dout[k] = 8'h00;
            m_rv[k]   = 1'b0;
            m_ov[k]   = 1'b0;
            m_un[k]   = 1'b0;
        end else begin
            racc = rd_en && (q.size() != 0);
            wacc = wr_en && ((q.size() != m_depth[k]) || racc);
            m_ov[k] = wr_en && !wacc;
            m_un[k] = rd_en && !racc;
            m_rv[k] = 1'b0;
            if (racc) begin
                h = q.pop_front();
`ifndef FIFO_FWFT_EN
                m_dout[k] = h;
                m_rv[k]   = 1'b1;
`endif
            end
            if (wacc) q.push_back(din);
        end
        if (k == 0) q8 = q; else q5 = q;
    endtask

    task automatic cmp(input int k, input int lvl, input logic fl, input logic em,
                       input logic af, input logic ae, input logic ov, input logic un,
                       input logic rv, input logic [7:0] dv);
        int         sz;
        logic [7:0] head;
        string      p;
        p    = (k == 0) ? "d8" : "d5";
        sz   = (k == 0) ? q8.size() : q5.size();
        head = 8'h00;
        if (sz != 0) head = (k == 0) ? q8[0] : q5[0];
        chk({p, ".level"}, lvl, sz);
        chk({p, ".full"}, int'(fl), int'(sz == m_depth[k]));
        chk({p, ".empty"}, int'(em), int'(sz == 0));
        chk({p, ".almost_full"}, int'(af), int'(sz >= m_af[k]));
        chk({p, ".almost_empty"}, int'(ae), int'(sz <= m_ae[k]));
        chk({p, ".overflow"}, int'(ov), int'(m_ov[k]));
        chk({p, ".underflow"}, int'(un), int'(m_un[k]));
`ifdef FIFO_FWFT_EN
        chk({p, ".rd_valid"}, int'(rv), int'(sz != 0));
        if (sz != 0) chk({p, ".dout"}, int'(dv), int'(head));
`else
        chk({p, ".rd_valid"}, int'(rv), int'(m_rv[k]));
        chk({p, ".dout"}, int'(dv), int'(m_dout[k]));
`endif
    endtask

    // Model advances on the same edge the DUTs sample their inputs.
    initial begin
        forever begin
            @(posedge clk);
            step(0);
            step(1);
            started = 1'b1;
        end
    end

    // Compare both DUTs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                cmp(0, int'(lvl8), full8, empty8, af8, ae8, ov8, un8, rv8, dout8);
                cmp(1, int'(lvl5), full5, empty5, af5, ae5, ov5, un5, rv5, dout5);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic w, input logic [7:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(negedge clk);
    endtask

    initial begin
        int wp, rp;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // reset state, literal
        chk("rst.level", int'(lvl8), 0);
        chk("rst.empty", int'(empty8), 1);
        chk("rst.full", int'(full8), 0);
        chk("rst.almost_empty", int'(ae8), 1);
        chk("rst.almost_full", int'(af8), 0);
        chk("rst.rd_valid", int'(rv8), 0);

        // 1: fill 0x01..0x08, then drain in order
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            chk("t1.level", int'(lvl8), i);
            chk("t1.almost_full", int'(af8), int'(i >= 6));
            chk("t1.full", int'(full8), int'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
            chk("t1.head", int'(dout8), i);
            drive(1'b0, 8'h00, 1'b1);
`else
            drive(1'b0, 8'h00, 1'b1);
            chk("t1.rd_valid", int'(rv8), 1);
            chk("t1.dout", int'(dout8), i);
`endif
        end
        chk("t1.empty", int'(empty8), 1);

        // 2: overflow at full, then simultaneous read/write at full
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        chk("t2.overflow", int'(ov8), 1);
        chk("t2.level", int'(lvl8), 8);
        drive(1'b1, 8'hBB, 1'b1);
        chk("t2.level_rw", int'(lvl8), 8);
        chk("t2.overflow_rw", int'(ov8), 0);
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
            if (i == 7) chk("t2.last", int'(dout8), 8'hBB);
            drive(1'b0, 8'h00, 1'b1);
`else
            drive(1'b0, 8'h00, 1'b1);
            if (i == 7) chk("t2.last", int'(dout8), 8'hBB);
`endif
        end

        // 3: underflow at empty, then simultaneous read/write at empty
        drive(1'b0, 8'h00, 1'b1);
        chk("t3.underflow", int'(un8), 1);
        chk("t3.level", int'(lvl8), 0);
`ifndef FIFO_FWFT_EN
        chk("t3.rd_valid", int'(rv8), 0);
`endif
        drive(1'b1, 8'h5A, 1'b1);
        chk("t3.level_rw", int'(lvl8), 1);
        chk("t3.underflow_rw", int'(un8), 1);
`ifdef FIFO_FWFT_EN
        chk("t3.head", int'(dout8), 8'h5A);
        drive(1'b0, 8'h00, 1'b1);
`else
        drive(1'b0, 8'h00, 1'b1);
        chk("t3.dout", int'(dout8), 8'h5A);
`endif

        // 4: DEPTH=5 wrap: 3 prefills then write+read each cycle
        rst = 1'b1; drive(1'b0, 8'h00, 1'b0); rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
        chk("t4.prefill", int'(lvl5), 3);
        for (int i = 0; i < 12; i++) begin
`ifdef FIFO_FWFT_EN
            chk("t4.head", int'(dout5), (i < 3) ? 8'h40 + i : 8'h50 + i - 3);
            drive(1'b1, 8'(8'h50 + i), 1'b1);
`else
            drive(1'b1, 8'(8'h50 + i), 1'b1);
            chk("t4.dout", int'(dout5), (i < 3) ? 8'h40 + i : 8'h50 + i - 3);
`endif
            chk("t4.level", int'(lvl5), 3);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1);

        // 5: reset mid-stream with wr_en high discards contents
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b0);
        rst = 1'b1; drive(1'b1, 8'h77, 1'b0); rst = 1'b0;
        chk("t5.level", int'(lvl8), 0);
        chk("t5.empty", int'(empty8), 1);
        chk("t5.rd_valid", int'(rv8), 0);
        drive(1'b0, 8'h00, 1'b1);
        chk("t5.underflow", int'(un8), 1);
        chk("t5.rd_valid_after", int'(rv8), 0);

`ifdef FIFO_FWFT_EN
        // 6: fall-through behaviour
        drive(1'b1, 8'h11, 1'b0);
        chk("t6.rd_valid", int'(rv8), 1);
        chk("t6.dout", int'(dout8), 8'h11);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk("t6.dout_next", int'(dout8), 8'h22);
        drive(1'b0, 8'h00, 1'b1);
`endif

        // randomized traffic with varying bias and occasional reset
        for (int blk = 0; blk < 6; blk++) begin
            wp = (blk % 2 == 0) ? 70 : 30;
            rp = (blk % 2 == 0) ? 35 : 75;
            for (int c = 0; c < 500; c++) begin
                rst = ($urandom_range(0, 199) == 0);
                drive(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp));
            end
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
